// File: rtl/trigger_sequencer.sv
// Multi-stage trigger controller: steps through stored trigger configurations with
// per-stage repeat counts and a per-stage timeout, pulsing seq_trigger when the final stage completes.
module trigger_sequencer #(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic        clk,
  input  logic        rst_n_sync,
  input  logic        cfg_wr_en,
  input  logic [1:0]  cfg_wr_stage,
  input  logic [31:0] cfg_wr_data,
  input  logic [1:0]  cfg_last_stage,
  input  logic [15:0] cfg_timeout,
  input  logic        arm,
  input  logic        abort,
  input  logic        trig_in,
  output logic        trig_cfg_enable,
  output logic        trig_cfg_positive,
  output logic [2:0]  trig_cfg_type,
  output logic [7:0]  trig_cfg_count1,
  output logic [7:0]  trig_cfg_count2,
  output logic [3:0]  trig_cfg_stage1_count,
  output logic [2:0]  trig_cfg_time_base,
  output logic        trig_cfg_longer_no_edge,
  output logic        seq_trigger,
  output logic        busy,
  output logic        done,
  output logic        timeout_flag,
  output logic [1:0]  cur_stage
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_GAP,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t      state;
  logic [31:0] mem [NUM_STAGES];
  logic [3:0]  occ_cnt;
  logic [7:0]  prescaler;
  logic [15:0] tmo_cnt;
  logic        trig_in_d;

  logic [31:0] cur_cfg;
  logic [3:0]  rep_eff;
  logic [1:0]  last_eff;
  logic        edge_det;
  logic        occ_hit;
  logic        tmo_hit;
  logic        wr_ok;

  always_comb begin
    cur_cfg  = mem[cur_stage];
    rep_eff  = (cur_cfg[31:28] == 4'd0) ? 4'd1 : cur_cfg[31:28];
    last_eff = (32'(cfg_last_stage) > NUM_STAGES - 1) ? 2'(NUM_STAGES - 1) : cfg_last_stage;
    edge_det = trig_in & ~trig_in_d;
    occ_hit  = ({1'b0, occ_cnt} + 5'd1) == {1'b0, rep_eff};
    tmo_hit  = (cfg_timeout != 16'd0) && (tmo_cnt == cfg_timeout);
    wr_ok    = cfg_wr_en && (32'(cfg_wr_stage) < NUM_STAGES) &&
               (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[cfg_wr_stage] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state       <= S_IDLE;
      cur_stage   <= '0;
      occ_cnt     <= '0;
      prescaler   <= '0;
      tmo_cnt     <= '0;
      trig_in_d   <= 1'b0;
      seq_trigger <= 1'b0;
    end else begin
      trig_in_d   <= trig_in;
      seq_trigger <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        cur_stage <= '0;
        occ_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_TIMEOUT: begin
            if (arm) begin
              state     <= S_LOAD;
              cur_stage <= '0;
              occ_cnt   <= '0;
              prescaler <= '0;
              tmo_cnt   <= '0;
            end
          end
          S_LOAD: state <= S_ARM;
          S_ARM: begin
            prescaler <= prescaler + 8'd1;
            if (prescaler == 8'hFF && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
            // an edge in the same cycle as the timeout match wins
            if (edge_det) begin
              occ_cnt <= occ_cnt + 4'd1;
              if (occ_hit) begin
                if (cur_stage >= last_eff) begin
                  seq_trigger <= 1'b1;
                  state       <= S_DONE;
                end else begin
                  cur_stage <= cur_stage + 2'd1;
                  state     <= S_GAP;
                end
              end
            end else if (tmo_hit) begin
              state <= S_TIMEOUT;
            end
          end
          S_GAP: begin
            if (!trig_in) begin
              state     <= S_LOAD;
              occ_cnt   <= '0;
              prescaler <= '0;
              tmo_cnt   <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign trig_cfg_enable         = (state == S_ARM);
  assign busy                    = (state == S_LOAD) || (state == S_ARM) || (state == S_GAP);
  assign done                    = (state == S_DONE);
  assign timeout_flag            = (state == S_TIMEOUT);
  assign trig_cfg_positive       = cur_cfg[0];
  assign trig_cfg_type           = cur_cfg[3:1];
  assign trig_cfg_count1         = cur_cfg[11:4];
  assign trig_cfg_count2         = cur_cfg[19:12];
  assign trig_cfg_stage1_count   = cur_cfg[23:20];
  assign trig_cfg_time_base      = cur_cfg[26:24];
  assign trig_cfg_longer_no_edge = cur_cfg[27];

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: stage stepping, repeats, timeout, abort,
// write protection and asynchronous reset.
module tb_trigger_sequencer;

  logic        clk;
  logic        rst_n_sync;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_stage;
  logic [31:0] cfg_wr_data;
  logic [1:0]  cfg_last_stage;
  logic [15:0] cfg_timeout;
  logic        arm;
  logic        abort;
  logic        trig_in;
  logic        trig_cfg_enable;
  logic        trig_cfg_positive;
  logic [2:0]  trig_cfg_type;
  logic [7:0]  trig_cfg_count1;
  logic [7:0]  trig_cfg_count2;
  logic [3:0]  trig_cfg_stage1_count;
  logic [2:0]  trig_cfg_time_base;
  logic        trig_cfg_longer_no_edge;
  logic        seq_trigger;
  logic        busy;
  logic        done;
  logic        timeout_flag;
  logic [1:0]  cur_stage;

  int vectors = 0;
  int miscompares = 0;

  trigger_sequencer #(.NUM_STAGES(4)) dut (
    .clk(clk),
    .rst_n_sync(rst_n_sync),
    .cfg_wr_en(cfg_wr_en),
    .cfg_wr_stage(cfg_wr_stage),
    .cfg_wr_data(cfg_wr_data),
    .cfg_last_stage(cfg_last_stage),
    .cfg_timeout(cfg_timeout),
    .arm(arm),
    .abort(abort),
    .trig_in(trig_in),
    .trig_cfg_enable(trig_cfg_enable),
    .trig_cfg_positive(trig_cfg_positive),
    .trig_cfg_type(trig_cfg_type),
    .trig_cfg_count1(trig_cfg_count1),
    .trig_cfg_count2(trig_cfg_count2),
    .trig_cfg_stage1_count(trig_cfg_stage1_count),
    .trig_cfg_time_base(trig_cfg_time_base),
    .trig_cfg_longer_no_edge(trig_cfg_longer_no_edge),
    .seq_trigger(seq_trigger),
    .busy(busy),
    .done(done),
    .timeout_flag(timeout_flag),
    .cur_stage(cur_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic pos, input logic [2:0] typ, input logic [7:0] c1,
                                     input logic [7:0] c2, input logic [3:0] s1, input logic [2:0] tb,
                                     input logic lne, input logic [3:0] rep);
    return {rep, lne, tb, s1, c2, c1, typ, pos};
  endfunction

  function automatic logic [63:0] outs();
    return {29'd0, trig_cfg_enable, trig_cfg_positive, trig_cfg_type, trig_cfg_count1,
            trig_cfg_count2, trig_cfg_stage1_count, trig_cfg_time_base, trig_cfg_longer_no_edge,
            seq_trigger, busy, done, timeout_flag, cur_stage};
  endfunction

  task automatic wr(input logic [1:0] idx, input logic [31:0] data);
    cfg_wr_en = 1'b1;
    cfg_wr_stage = idx;
    cfg_wr_data = data;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // 8-clk trig_in pulse followed by a 20-clk gap; counts seq_trigger cycles seen
  task automatic pulse(output int seq_seen);
    seq_seen = 0;
    trig_in = 1'b1;
    repeat (8) begin
      tick();
      seq_seen += int'(seq_trigger);
    end
    trig_in = 1'b0;
    repeat (20) begin
      tick();
      seq_seen += int'(seq_trigger);
    end
  endtask

  initial begin
    int n;
    int seq_acc;
    rst_n_sync = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_wr_stage = '0;
    cfg_wr_data = '0;
    cfg_last_stage = '0;
    cfg_timeout = '0;
    arm = 1'b0;
    abort = 1'b0;
    trig_in = 1'b0;
    #2;
    chk("reset_outputs", outs(), 64'd0);
    #10;
    rst_n_sync = 1'b1;
    tick();

    // single stage, repeat 1
    wr(2'd0, mk(1'b1, 3'd0, 8'h12, 8'h34, 4'h5, 3'h6, 1'b1, 4'd1));
    chk("t1_cfg_fields", {trig_cfg_positive, trig_cfg_type, trig_cfg_count1, trig_cfg_count2,
        trig_cfg_stage1_count, trig_cfg_time_base, trig_cfg_longer_no_edge},
        {1'b1, 3'd0, 8'h12, 8'h34, 4'h5, 3'h6, 1'b1});
    cfg_last_stage = 2'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t1_load_enable", {busy, trig_cfg_enable}, 2'b10);
    tick();
    chk("t1_arm_enable", {busy, trig_cfg_enable}, 2'b11);
    trig_in = 1'b1;
    tick();
    chk("t1_seq_done", {seq_trigger, done, trig_cfg_enable, busy}, 4'b1100);
    tick();
    chk("t1_seq_one_clk", seq_trigger, 1'b0);
    repeat (6) tick();
    trig_in = 1'b0;
    tick();
    chk("t1_done_hold", {done, seq_trigger}, 2'b10);

    // three stages, repeats 1, 3, 2
    wr(2'd0, mk(1'b1, 3'd1, 8'h11, 8'h01, 4'h1, 3'h1, 1'b0, 4'd1));
    wr(2'd1, mk(1'b0, 3'd2, 8'h22, 8'h02, 4'h2, 3'h2, 1'b1, 4'd3));
    wr(2'd2, mk(1'b1, 3'd3, 8'h33, 8'h03, 4'h3, 3'h3, 1'b0, 4'd2));
    cfg_last_stage = 2'd2;
    do_arm();
    chk("t2_arm_s0", {trig_cfg_enable, cur_stage, trig_cfg_type, trig_cfg_count1}, {1'b1, 2'd0, 3'd1, 8'h11});
    trig_in = 1'b1;
    tick();
    chk("t2_p1_gap", {cur_stage, trig_cfg_enable, busy, seq_trigger}, {2'd1, 1'b0, 1'b1, 1'b0});
    repeat (7) tick();
    chk("t2_gap_hold", {trig_cfg_enable, busy}, 2'b01);
    trig_in = 1'b0;
    tick();
    chk("t2_load_s1", {trig_cfg_enable, busy, trig_cfg_type, trig_cfg_count1, trig_cfg_positive},
        {1'b0, 1'b1, 3'd2, 8'h22, 1'b0});
    tick();
    chk("t2_arm_s1", trig_cfg_enable, 1'b1);
    repeat (18) tick();
    seq_acc = 0;
    pulse(n);
    seq_acc += n;
    pulse(n);
    seq_acc += n;
    chk("t2_p3_stage", cur_stage, 2'd1);
    pulse(n);
    seq_acc += n;
    chk("t2_p4_stage", {cur_stage, trig_cfg_count1, trig_cfg_type}, {2'd2, 8'h33, 3'd3});
    pulse(n);
    seq_acc += n;
    chk("t2_p5_stage", {cur_stage, busy}, {2'd2, 1'b1});
    chk("t2_no_early_seq", seq_acc, 0);
    trig_in = 1'b1;
    tick();
    chk("t2_p6_seq", {seq_trigger, done, trig_cfg_enable}, 3'b110);
    tick();
    chk("t2_p6_seq_end", seq_trigger, 1'b0);
    repeat (6) tick();
    trig_in = 1'b0;
    tick();

    // timeout: 2 x 256 clk
    cfg_last_stage = 2'd0;
    cfg_timeout = 16'd2;
    do_arm();
    n = 0;
    while (!timeout_flag && n < 600) begin
      tick();
      n++;
    end
    chk("t3_tmo_latency", (n >= 511 && n <= 513), 1'b1);
    chk("t3_tmo_state", {timeout_flag, trig_cfg_enable, busy, done}, 4'b1000);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t3_rearm", {timeout_flag, busy, cur_stage}, {1'b0, 1'b1, 2'd0});
    cfg_timeout = 16'd0;
    do_abort();
    chk("t3_abort_idle", {busy, done, timeout_flag, trig_cfg_enable}, 4'b0000);

    // abort mid-GAP in stage 1
    cfg_last_stage = 2'd2;
    do_arm();
    trig_in = 1'b1;
    tick();
    chk("t4_in_gap", {cur_stage, busy, trig_cfg_enable}, {2'd1, 1'b1, 1'b0});
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort", {cur_stage, busy, seq_trigger, trig_cfg_enable, done}, {2'd0, 4'b0000});
    repeat (5) tick();
    trig_in = 1'b0;
    tick();
    chk("t4_idle_hold", {busy, seq_trigger}, 2'b00);
    do_arm();
    chk("t4_restart_s0", {trig_cfg_enable, cur_stage, trig_cfg_type}, {1'b1, 2'd0, 3'd1});
    pulse(n);
    chk("t4_advance_s1", {cur_stage, trig_cfg_enable}, {2'd1, 1'b1});
    chk("t4_no_seq", n, 0);

    // write protection while busy
    wr(2'd1, mk(1'b1, 3'd7, 8'hEE, 8'hEE, 4'hE, 3'h7, 1'b0, 4'd1));
    chk("t5_wr_dropped", {trig_cfg_count1, trig_cfg_type, trig_cfg_positive}, {8'h22, 3'd2, 1'b0});
    do_abort();

    // repeat 0 acts as 1
    wr(2'd0, mk(1'b0, 3'd4, 8'h44, 8'h00, 4'h0, 3'h0, 1'b0, 4'd0));
    cfg_last_stage = 2'd0;
    do_arm();
    trig_in = 1'b1;
    tick();
    chk("t5_rep0", {seq_trigger, done}, 2'b11);
    repeat (7) tick();
    trig_in = 1'b0;
    tick();

    // edge coinciding with the timeout match: stage advances
    wr(2'd0, mk(1'b0, 3'd4, 8'h44, 8'h00, 4'h0, 3'h0, 1'b0, 4'd1));
    cfg_last_stage = 2'd1;
    cfg_timeout = 16'd1;
    do_arm();
    repeat (256) tick();
    chk("t5_pre_tmo", {timeout_flag, cur_stage, trig_cfg_enable}, {1'b0, 2'd0, 1'b1});
    trig_in = 1'b1;
    tick();
    chk("t5_edge_wins", {cur_stage, timeout_flag, busy}, {2'd1, 1'b0, 1'b1});
    repeat (7) tick();
    trig_in = 1'b0;
    tick();
    cfg_timeout = 16'd0;
    do_abort();

    // asynchronous reset while armed with nonzero cfg
    wr(2'd0, mk(1'b1, 3'd5, 8'h55, 8'h66, 4'h7, 3'h2, 1'b1, 4'd1));
    cfg_last_stage = 2'd0;
    do_arm();
    chk("t6_armed", {trig_cfg_enable, trig_cfg_count1}, {1'b1, 8'h55});
    #2;
    rst_n_sync = 1'b0;
    #1;
    chk("t6_async_reset", outs(), 64'd0);
    #2;
    rst_n_sync = 1'b1;
    tick();
    chk("t6_mem0_cleared", outs(), 64'd0);
    cfg_last_stage = 2'd1;
    do_arm();
    trig_in = 1'b1;
    tick();
    chk("t6_mem1_cleared", {cur_stage, trig_cfg_count1, trig_cfg_type, trig_cfg_positive},
        {2'd1, 8'h00, 3'd0, 1'b0});
    repeat (7) tick();
    trig_in = 1'b0;
    tick();
    tick();
    trig_in = 1'b1;
    tick();
    chk("t6_final_seq", {seq_trigger, done}, 2'b11);
    trig_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
